cactus_draw: RTL and testbench

CACTUS_DRAW -- requirements
Module: cactus_draw

---
 rtl/cactus_draw.sv | 77 +++++++
 tb/tb_cactus_draw.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cactus_draw.sv
// cactus_draw: erases the previous two cacti and draws the new ones as a
// sequence of rectangle fill requests to a display writer.
module cactus_draw #(
  parameter int          CACTUS_W = 10,
  parameter int          GROUND_Y = 200,
  parameter int          SCREEN_W = 320,
  parameter logic [15:0] FG_COLOR = 16'h07E0,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cactus_movement,
  input  logic [8:0]  pixel,
  input  logic [8:0]  x_dist,
  input  logic [8:0]  height1,
  input  logic [8:0]  height2,
  input  logic        rect_ready,
  output logic        rect_valid,
  output logic [8:0]  rect_x0,
  output logic [8:0]  rect_x1,
  output logic [7:0]  rect_y0,
  output logic [7:0]  rect_y1,
  output logic [15:0] rect_color,
  output logic        draw_done
);
  typedef enum logic [2:0] {IDLE, ERASE1, ERASE2, DRAW1, DRAW2, DONE} state_t;
  localparam logic [8:0] GY   = 9'(GROUND_Y);
  localparam logic [7:0] Y1   = 8'(GROUND_Y - 1);
  localparam logic [9:0] SW   = 10'(SCREEN_W);
  localparam logic [9:0] XMAX = 10'(SCREEN_W - 1);
  state_t state_q, state_d;
  logic [8:0] new_px_q, new_xd_q, new_h1_q, new_h2_q;
  logic [8:0] old_px_q, old_xd_q, old_h1_q, old_h2_q;
  logic old_valid_q;
  logic in_rect, erase, second, vis;
  logic [8:0] px, xd, h, x0, y0w;
  logic [9:0] x1w;
  always_comb begin
    in_rect = state_q inside {ERASE1, ERASE2, DRAW1, DRAW2};
    erase = state_q inside {ERASE1, ERASE2};
    second = state_q inside {ERASE2, DRAW2};
    px = erase ? old_px_q : new_px_q;
    xd = erase ? old_xd_q : new_xd_q;
    h = erase ? (second ? old_h2_q : old_h1_q) : (second ? new_h2_q : new_h1_q);
    // cactus 2 sits x_dist behind cactus 1; this subtraction alone may wrap
    x0 = second ? px - xd : px;
    x1w = {1'b0, x0} + 10'(CACTUS_W - 1);
    y0w = (h >= GY) ? 9'd0 : GY - h;
    vis = in_rect && (!erase || old_valid_q) && ({1'b0, x0} < SW) && (h != 9'd0);
    rect_valid = vis;
    rect_x0 = in_rect ? x0 : '0;
    rect_x1 = in_rect ? ((x1w > XMAX) ? XMAX[8:0] : x1w[8:0]) : '0;
    rect_y0 = in_rect ? y0w[7:0] : '0;
    rect_y1 = in_rect ? Y1 : '0;
    rect_color = in_rect ? (erase ? BG_COLOR : FG_COLOR) : '0;
    draw_done = state_q == DONE;
    state_d = (state_q == IDLE) ? (cactus_movement ? ERASE1 : IDLE) :
              (state_q == DONE) ? IDLE :
              (vis && !rect_ready) ? state_q : state_t'(state_q + 3'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      old_valid_q <= 1'b0;
      {new_px_q, new_xd_q, new_h1_q, new_h2_q} <= '0;
      {old_px_q, old_xd_q, old_h1_q, old_h2_q} <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cactus_movement)
        {new_px_q, new_xd_q, new_h1_q, new_h2_q} <= {pixel, x_dist, height1, height2};
      if (state_q == DONE) begin
        {old_px_q, old_xd_q, old_h1_q, old_h2_q} <= {new_px_q, new_xd_q, new_h1_q, new_h2_q};
        old_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cactus_draw.sv
// tb_cactus_draw: directed scenarios for the cactus erase/draw sequencer.
module tb_cactus_draw;
  logic clk = 0, rst = 1;
  logic cactus_movement = 0, rect_ready = 1;
  logic [8:0] pixel = 0, x_dist = 0, height1 = 0, height2 = 0;
  logic rect_valid, draw_done;
  logic [8:0] rect_x0, rect_x1;
  logic [7:0] rect_y0, rect_y1;
  logic [15:0] rect_color;
  int checks = 0, errors = 0;
  logic [49:0] acc [16];
  logic tv [32];
  logic [49:0] trect [32];
  int nacc, done1, done2;

  cactus_draw dut (
    .clk(clk), .rst(rst), .cactus_movement(cactus_movement), .pixel(pixel),
    .x_dist(x_dist), .height1(height1), .height2(height2), .rect_ready(rect_ready),
    .rect_valid(rect_valid), .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0),
    .rect_y1(rect_y1), .rect_color(rect_color), .draw_done(draw_done)
  );

  always #5 clk = ~clk;

  // Issues one request and records ncyc cycles after the sampling edge;
  // cycle k is observed at the k-th falling edge after that edge.
  task automatic run_seq(input logic [8:0] px, xd, h1, h2, input bit hold,
                         input int stall, input int ncyc);
    int left, nd;
    bit started;
    left = 0; nd = 0; started = 0; nacc = 0; done1 = 0; done2 = 0;
    for (int i = 0; i < 16; i++) acc[i] = 'x;
    for (int i = 0; i < 32; i++) begin tv[i] = 1'bx; trect[i] = 'x; end
    @(negedge clk);
    pixel = px; x_dist = xd; height1 = h1; height2 = h2;
    cactus_movement = 1; rect_ready = 1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (!hold || k == ncyc) cactus_movement = 0;
      if (stall > 0 && !started && rect_valid && rect_color == 16'h07E0) begin
        started = 1; left = stall;
      end
      rect_ready = (left == 0);
      if (left > 0) left--;
      tv[k] = rect_valid;
      trect[k] = {rect_x0, rect_x1, rect_y0, rect_y1, rect_color};
      if (rect_valid && rect_ready && nacc < 16) begin acc[nacc] = trect[k]; nacc++; end
      if (draw_done) begin
        nd++;
        if (nd == 1) done1 = k; else if (nd == 2) done2 = k;
      end
    end
    rect_ready = 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (rect_valid !== 1'b0 || draw_done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl valid=%b done=%b expected 0 0", rect_valid, draw_done);
    end
    checks++;
    if ({rect_x0, rect_x1, rect_y0, rect_y1, rect_color} !== 50'd0) begin
      errors++; $display("FAIL reset_rect got %h expected 0", {rect_x0, rect_x1, rect_y0, rect_y1, rect_color});
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (rect_valid !== 1'b0 || draw_done !== 1'b0) begin
      errors++; $display("FAIL idle_ctrl valid=%b done=%b expected 0 0", rect_valid, draw_done);
    end
  endtask

  task automatic test_first_draw;
    logic [49:0] e [2];
    e[0] = {9'd200, 9'd209, 8'd160, 8'd199, 16'h07E0};
    e[1] = {9'd70, 9'd79, 8'd185, 8'd199, 16'h07E0};
    run_seq(200, 130, 40, 15, 0, 0, 7);
    checks++;
    if (nacc !== 2) begin errors++; $display("FAIL first_count got %0d expected 2", nacc); end
    checks++;
    if (tv[1] !== 1'b0 || tv[2] !== 1'b0) begin
      errors++; $display("FAIL first_no_erase valid=%b%b expected 00", tv[1], tv[2]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL first_rect%0d got %h expected %h", i, acc[i], e[i]); end
    end
    checks++;
    if (done1 !== 5) begin errors++; $display("FAIL first_done_cycle got %0d expected 5", done1); end
  endtask

  task automatic test_erase_redraw;
    logic [49:0] e [4];
    e[0] = {9'd200, 9'd209, 8'd160, 8'd199, 16'h0000};
    e[1] = {9'd70, 9'd79, 8'd185, 8'd199, 16'h0000};
    e[2] = {9'd201, 9'd210, 8'd160, 8'd199, 16'h07E0};
    e[3] = {9'd71, 9'd80, 8'd185, 8'd199, 16'h07E0};
    run_seq(201, 130, 40, 15, 0, 0, 7);
    checks++;
    if (nacc !== 4) begin errors++; $display("FAIL redraw_count got %0d expected 4", nacc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL redraw_rect%0d got %h expected %h", i, acc[i], e[i]); end
    end
    checks++;
    if (done1 !== 5) begin errors++; $display("FAIL redraw_done_cycle got %0d expected 5", done1); end
  endtask

  task automatic test_screen_edge;
    logic [49:0] e;
    e = {9'd315, 9'd319, 8'd160, 8'd199, 16'h07E0};
    run_seq(315, 400, 40, 15, 0, 0, 7);
    checks++;
    if (nacc !== 3) begin errors++; $display("FAIL edge_count got %0d expected 3", nacc); end
    checks++;
    if (acc[2] !== e) begin errors++; $display("FAIL edge_clip got %h expected %h", acc[2], e); end
    checks++;
    if (tv[4] !== 1'b0) begin errors++; $display("FAIL edge_c2_hidden valid=%b expected 0", tv[4]); end
    checks++;
    if (done1 !== 5) begin errors++; $display("FAIL edge_done_cycle got %0d expected 5", done1); end
  endtask

  task automatic test_backpressure;
    logic [49:0] e;
    e = {9'd100, 9'd109, 8'd160, 8'd199, 16'h07E0};
    run_seq(100, 30, 40, 15, 0, 3, 10);
    for (int k = 3; k <= 6; k++) begin
      checks++;
      if (tv[k] !== 1'b1 || trect[k] !== e) begin
        errors++; $display("FAIL stall_hold cycle%0d valid=%b rect=%h expected 1 %h", k, tv[k], trect[k], e);
      end
    end
    checks++;
    if (nacc !== 3) begin errors++; $display("FAIL stall_count got %0d expected 3", nacc); end
    checks++;
    if (done1 !== 8) begin errors++; $display("FAIL stall_done_cycle got %0d expected 8", done1); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    pixel = 150; x_dist = 30; height1 = 40; height2 = 15; cactus_movement = 1;
    @(negedge clk);
    cactus_movement = 0;
    @(negedge clk);
    checks++;
    if (rect_valid !== 1'b1 || rect_color !== 16'h0000 || rect_x0 !== 9'd70) begin
      errors++; $display("FAIL mid_erase2 valid=%b color=%h x0=%0d expected 1 0000 70", rect_valid, rect_color, rect_x0);
    end
    rst = 1;
    #1;
    checks++;
    if (rect_valid !== 1'b0 || draw_done !== 1'b0) begin
      errors++; $display("FAIL mid_abort valid=%b done=%b expected 0 0", rect_valid, draw_done);
    end
    @(negedge clk);
    rst = 0;
    run_seq(150, 30, 40, 15, 0, 0, 7);
    checks++;
    if (tv[1] !== 1'b0 || tv[2] !== 1'b0 || nacc !== 2) begin
      errors++; $display("FAIL mid_no_erase valid=%b%b count=%0d expected 00 2", tv[1], tv[2], nacc);
    end
    checks++;
    if (acc[0] !== {9'd150, 9'd159, 8'd160, 8'd199, 16'h07E0}) begin
      errors++; $display("FAIL mid_draw got %h expected %h", acc[0], {9'd150, 9'd159, 8'd160, 8'd199, 16'h07E0});
    end
  endtask

  task automatic test_held_movement;
    logic [49:0] e [8];
    e[0] = {9'd150, 9'd159, 8'd160, 8'd199, 16'h0000};
    e[1] = {9'd120, 9'd129, 8'd185, 8'd199, 16'h0000};
    e[2] = {9'd100, 9'd109, 8'd0, 8'd199, 16'h07E0};
    e[3] = {9'd50, 9'd59, 8'd180, 8'd199, 16'h07E0};
    e[4] = {9'd100, 9'd109, 8'd0, 8'd199, 16'h0000};
    e[5] = {9'd50, 9'd59, 8'd180, 8'd199, 16'h0000};
    e[6] = e[2];
    e[7] = e[3];
    run_seq(100, 50, 250, 20, 1, 0, 12);
    checks++;
    if (nacc !== 8) begin errors++; $display("FAIL held_count got %0d expected 8", nacc); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc[i] !== e[i]) begin errors++; $display("FAIL held_rect%0d got %h expected %h", i, acc[i], e[i]); end
    end
    checks++;
    if (done1 !== 5 || done2 !== 11) begin
      errors++; $display("FAIL held_done_cycles got %0d %0d expected 5 11", done1, done2);
    end
    @(negedge clk);
    checks++;
    if (rect_valid !== 1'b0 || draw_done !== 1'b0) begin
      errors++; $display("FAIL held_idle valid=%b done=%b expected 0 0", rect_valid, draw_done);
    end
  endtask

  initial begin
    test_reset;
    test_first_draw;
    test_erase_redraw;
    test_screen_edge;
    test_backpressure;
    test_reset_mid;
    test_held_movement;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
